// File: rtl/minisys_stimulus_sequencer_if.sv
// minisys_stimulus_sequencer_if: run control, script-load port and Minisys board pins of the stimulus sequencer (master = controller/board side, slave = sequencer)
interface minisys_stimulus_sequencer_if #(
  parameter int SW_WIDTH = 24,
  parameter int BTN_WIDTH = 5,
  parameter int LED_WIDTH = 24,
  parameter int DEPTH = 16,
  parameter int DELAY_WIDTH = 16
);
  localparam int AW = $clog2(DEPTH);
  logic start;
  logic abort;
  logic [AW:0] script_len;
  logic script_wr_en;
  logic [AW-1:0] script_wr_addr;
  logic [DELAY_WIDTH-1:0] script_delay;
  logic [SW_WIDTH-1:0] script_sw_val;
  logic [SW_WIDTH-1:0] script_sw_mask;
  logic [BTN_WIDTH-1:0] script_btn;
  logic script_chk_en;
  logic [LED_WIDTH-1:0] script_exp_led;
  logic [LED_WIDTH-1:0] Minisys_Lights;
  logic [SW_WIDTH-1:0] Minisys_Switches;
  logic [BTN_WIDTH-1:0] Minisys_Button;
  logic busy;
  logic done;
  logic pass;
  logic [AW-1:0] step_idx;
  logic [7:0] mismatch_count;
  logic [AW-1:0] first_fail_step;
  modport master (
    output start, abort, script_len, script_wr_en, script_wr_addr, script_delay, script_sw_val,
           script_sw_mask, script_btn, script_chk_en, script_exp_led, Minisys_Lights,
    input  Minisys_Switches, Minisys_Button, busy, done, pass, step_idx, mismatch_count, first_fail_step
  );
  modport slave (
    input  start, abort, script_len, script_wr_en, script_wr_addr, script_delay, script_sw_val,
           script_sw_mask, script_btn, script_chk_en, script_exp_led, Minisys_Lights,
    output Minisys_Switches, Minisys_Button, busy, done, pass, step_idx, mismatch_count, first_fail_step
  );
endinterface

// File: rtl/minisys_stimulus_sequencer.sv
// minisys_stimulus_sequencer: replays a timed switch/button script onto Minisys board pins and checks the lights (Minisys_Clock/Minisys_Reset plain, all else via the slave modport)
module minisys_stimulus_sequencer #(
  parameter int SW_WIDTH = 24,
  parameter int BTN_WIDTH = 5,
  parameter int LED_WIDTH = 24,
  parameter int DEPTH = 16,
  parameter int DELAY_WIDTH = 16,
  parameter int PULSE_CYCLES = 5,
  parameter int LOOP = 0
) (
  input logic Minisys_Clock,
  input logic Minisys_Reset,
  minisys_stimulus_sequencer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(PULSE_CYCLES + 1);
  localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);
  typedef enum logic [2:0] {IDLE, LOAD, WAIT, APPLY, PULSE, CHECK, DONE} state_t;
  typedef struct packed {
    logic [DELAY_WIDTH-1:0] delay;
    logic [SW_WIDTH-1:0] val;
    logic [SW_WIDTH-1:0] mask;
    logic [BTN_WIDTH-1:0] btn;
    logic chk;
    logic [LED_WIDTH-1:0] exp;
  } entry_t;
  entry_t r_mem [DEPTH];
  entry_t w_ent;
  state_t r_state, w_next;
  logic [AW:0] r_len, w_len;
  logic [AW-1:0] r_step, r_ffs;
  logic [DELAY_WIDTH-1:0] r_cnt;
  logic [PW-1:0] r_pcnt;
  logic [SW_WIDTH-1:0] r_sw, w_sw;
  logic [BTN_WIDTH-1:0] r_btn, w_btn;
  logic [7:0] r_mis, w_mis;
  logic r_busy, r_done, r_pass;
  logic w_start, w_last, w_fail;
  assign w_ent = r_mem[r_step];
  assign w_len = bus.script_len > LEN_MAX ? LEN_MAX : bus.script_len;
  assign w_start = bus.start && !bus.abort && (r_state == IDLE || r_state == DONE);
  assign w_last = {1'b0, r_step} == r_len - 1'b1;
  assign w_fail = r_state == CHECK && w_ent.chk && bus.Minisys_Lights != w_ent.exp;
  assign w_mis = w_fail && r_mis != 8'hff ? r_mis + 1'b1 : r_mis;
  always_ff @(posedge Minisys_Clock) begin
    if (bus.script_wr_en && !r_busy)
      r_mem[bus.script_wr_addr] <= '{bus.script_delay, bus.script_sw_val, bus.script_sw_mask,
                                     bus.script_btn, bus.script_chk_en, bus.script_exp_led};
  end
  always_ff @(posedge Minisys_Clock) r_state <= Minisys_Reset ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    if (bus.abort) w_next = IDLE;
    else case (r_state)
      IDLE, DONE: if (bus.start) w_next = w_len == '0 ? DONE : LOAD;
      LOAD: w_next = WAIT;
      WAIT: if (r_cnt == '0) w_next = APPLY;
      APPLY: w_next = r_btn != '0 && PULSE_CYCLES > 1 ? PULSE : CHECK;
      PULSE: if (r_pcnt == '0) w_next = CHECK;
      CHECK: w_next = w_last && LOOP == 0 ? DONE : LOAD;
      default: w_next = IDLE;
    endcase
  end
  // Switches and button are loaded on the edge entering APPLY so they land delay+2 cycles after LOAD
  always_comb begin
    w_sw = w_next == APPLY ? (r_sw & ~w_ent.mask) | (w_ent.val & w_ent.mask) : r_sw;
    w_btn = w_next == APPLY ? w_ent.btn : w_next == PULSE ? r_btn : '0;
  end
  always_ff @(posedge Minisys_Clock) begin
    if (Minisys_Reset) begin
      r_sw <= '0;
      r_btn <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_pass <= 1'b0;
      r_len <= '0;
      r_step <= '0;
      r_ffs <= '0;
      r_mis <= '0;
      r_cnt <= '0;
      r_pcnt <= '0;
    end else begin
      r_sw <= w_sw;
      r_btn <= w_btn;
      r_busy <= w_next inside {LOAD, WAIT, APPLY, PULSE, CHECK};
      r_done <= w_next == DONE;
      r_pass <= w_next == DONE && (w_start || w_mis == '0);
      if (w_start) begin
        r_len <= w_len;
        r_step <= '0;
        r_ffs <= '0;
        r_mis <= '0;
      end else if (!bus.abort) begin
        if (r_state == LOAD) r_cnt <= w_ent.delay;
        if (r_state == WAIT) r_cnt <= r_cnt - 1'b1;
        if (r_state == APPLY) r_pcnt <= PW'(PULSE_CYCLES - 2);
        if (r_state == PULSE) r_pcnt <= r_pcnt - 1'b1;
        if (r_state == CHECK) begin
          r_mis <= w_mis;
          if (w_fail && r_mis == '0) r_ffs <= r_step;
          if (!w_last) r_step <= r_step + 1'b1;
          else if (LOOP != 0) r_step <= '0;
        end
      end
    end
  end
  assign bus.Minisys_Switches = r_sw;
  assign bus.Minisys_Button = r_btn;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.pass = r_pass;
  assign bus.step_idx = r_step;
  assign bus.mismatch_count = r_mis;
  assign bus.first_fail_step = r_ffs;
endmodule

// File: tb/tb_minisys_stimulus_sequencer.sv
// tb_minisys_stimulus_sequencer: directed scoreboard bench for the stimulus sequencer (LOOP=0 and LOOP=1 instances share stimulus)
module tb_minisys_stimulus_sequencer;
  localparam int PULSE = 5;
  typedef struct {int t; logic [23:0] sw; logic [4:0] btn;} ev_t;
  logic clk = 0, rst = 1;
  logic start = 0, abort = 0, wr_en = 0, wr_chk = 0;
  logic [4:0] script_len = '0;
  logic [3:0] wr_addr = '0;
  logic [15:0] wr_delay = '0;
  logic [23:0] wr_val = '0, wr_mask = '0, wr_exp = '0, lights = '0;
  logic [4:0] wr_btn = '0;
  logic [15:0] m_delay [16];
  logic [23:0] m_val [16], m_mask [16], m_exp [16];
  logic [4:0] m_btn [16];
  bit m_chk [16];
  logic [23:0] m_sw = '0;
  ev_t q[$];
  int checks = 0, errors = 0;
  minisys_stimulus_sequencer_if if0 ();
  minisys_stimulus_sequencer_if if1 ();
  minisys_stimulus_sequencer #(.PULSE_CYCLES(PULSE), .LOOP(0)) dut0 (.Minisys_Clock(clk), .Minisys_Reset(rst), .bus(if0));
  minisys_stimulus_sequencer #(.PULSE_CYCLES(PULSE), .LOOP(1)) dut1 (.Minisys_Clock(clk), .Minisys_Reset(rst), .bus(if1));
  assign if0.start = start; assign if1.start = start;
  assign if0.abort = abort; assign if1.abort = abort;
  assign if0.script_len = script_len; assign if1.script_len = script_len;
  assign if0.script_wr_en = wr_en; assign if1.script_wr_en = wr_en;
  assign if0.script_wr_addr = wr_addr; assign if1.script_wr_addr = wr_addr;
  assign if0.script_delay = wr_delay; assign if1.script_delay = wr_delay;
  assign if0.script_sw_val = wr_val; assign if1.script_sw_val = wr_val;
  assign if0.script_sw_mask = wr_mask; assign if1.script_sw_mask = wr_mask;
  assign if0.script_btn = wr_btn; assign if1.script_btn = wr_btn;
  assign if0.script_chk_en = wr_chk; assign if1.script_chk_en = wr_chk;
  assign if0.script_exp_led = wr_exp; assign if1.script_exp_led = wr_exp;
  assign if0.Minisys_Lights = lights; assign if1.Minisys_Lights = lights;
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wr(input int a, input int d, input logic [23:0] v, input logic [23:0] mk,
                    input logic [4:0] b, input bit ce, input logic [23:0] ex);
    wr_en = 1; wr_addr = a[3:0]; wr_delay = d[15:0]; wr_val = v; wr_mask = mk; wr_btn = b; wr_chk = ce; wr_exp = ex;
    tick();
    wr_en = 0;
    m_delay[a] = d[15:0]; m_val[a] = v; m_mask[a] = mk; m_btn[a] = b; m_chk[a] = ce; m_exp[a] = ex;
  endtask
  task automatic pulse_abort();
    abort = 1;
    tick();
    abort = 0;
  endtask
  task automatic run_script(input int len, input logic [23:0] lv, input bit inject);
    int t, ap, hold, done_t, c, e_mis, e_ffs;
    logic [23:0] nsw;
    logic [28:0] prev;
    ev_t ev;
    q.delete();
    t = 1; e_mis = 0; e_ffs = 0; prev = {m_sw, 5'd0};
    for (int s = 0; s < len; s++) begin
      ap = t + int'(m_delay[s]) + 2;
      nsw = (m_sw & ~m_mask[s]) | (m_val[s] & m_mask[s]);
      if (nsw != m_sw || m_btn[s] != 0) q.push_back('{ap, nsw, m_btn[s]});
      m_sw = nsw;
      hold = m_btn[s] != 0 ? PULSE : 1;
      if (m_btn[s] != 0) q.push_back('{ap + hold, nsw, 5'd0});
      if (m_chk[s] && m_exp[s] != lv) begin
        if (e_mis == 0) e_ffs = s;
        e_mis++;
      end
      t = ap + hold + 1;
    end
    done_t = t;
    lights = lv; script_len = len[4:0]; start = 1;
    tick();
    start = 0; c = 1;
    chk("run_busy", if0.busy, 1);
    chk("run_idx0", if0.step_idx, 0);
    while (c <= done_t + 4) begin
      if (inject && c == 5) begin
        start = 1; script_len = 0; wr_en = 1; wr_addr = 0; wr_delay = 1; wr_val = '1; wr_mask = '1; wr_btn = '1;
      end
      if (inject && c == 6) begin
        chk("busy_ignore_start", if0.busy, 1);
        start = 0; script_len = len[4:0]; wr_en = 0;
      end
      if ({if0.Minisys_Switches, if0.Minisys_Button} != prev) begin
        if (q.size() == 0) chk("unexpected_change_t", c, 0);
        else begin
          ev = q.pop_front();
          chk("ev_time", c, ev.t);
          chk("ev_sw", if0.Minisys_Switches, ev.sw);
          chk("ev_btn", if0.Minisys_Button, ev.btn);
        end
        prev = {if0.Minisys_Switches, if0.Minisys_Button};
      end
      if (if0.done) break;
      tick();
      c++;
    end
    chk("done_time", c, done_t);
    chk("ev_left", q.size(), 0);
    chk("pass", if0.pass, e_mis == 0);
    chk("mismatch", if0.mismatch_count, e_mis);
    chk("first_fail", if0.first_fail_step, e_ffs);
    chk("idle_busy", if0.busy, 0);
  endtask
  initial begin
    int wraps, pidx;
    repeat (3) tick();
    chk("rst_sw", if0.Minisys_Switches, 0);
    chk("rst_btn", if0.Minisys_Button, 0);
    chk("rst_busy", if0.busy, 0);
    chk("rst_done", if0.done, 0);
    chk("rst_pass", if0.pass, 0);
    chk("rst_idx", if0.step_idx, 0);
    chk("rst_mis", if0.mismatch_count, 0);
    chk("rst_ffs", if0.first_fail_step, 0);
    rst = 0;
    tick();
    wr(0, 10, 24'h200000, 24'h200000, 0, 0, 0);
    wr(1, 5, 24'h000003, 24'h000003, 0, 0, 0);
    wr(2, 0, 24'h010000, 24'h010000, 0, 0, 0);
    run_script(3, 24'h0, 0);
    pulse_abort();
    chk("abort_clears_done", if0.done, 0);
    wr(0, 2, 24'h0, 24'h0, 5'b01000, 0, 0);
    wr(1, 1, 24'h0, 24'h0, 0, 1, 24'h000000);
    wr(2, 3, 24'h000005, 24'h00000f, 0, 1, 24'habcdef);
    run_script(3, 24'habcdef, 0);
    pulse_abort();
    rst = 1;
    tick();
    rst = 0;
    m_sw = '0;
    wr(0, 0, 24'h1, 24'h1, 5'b00001, 0, 0);
    wr(1, 1, 24'h2, 24'h2, 0, 0, 0);
    for (int s = 0; s < 2; s++) m_sw = (m_sw & ~m_mask[s]) | (m_val[s] & m_mask[s]);
    script_len = 2; start = 1;
    tick();
    start = 0;
    wraps = 0; pidx = 0;
    for (int c = 0; c < 400 && !(wraps == 3 && if1.Minisys_Button != 0); c++) begin
      tick();
      if (int'(if1.step_idx) != pidx) begin
        chk("loop_idx", if1.step_idx, (pidx + 1) % 2);
        if (if1.step_idx == 0) wraps++;
        pidx = int'(if1.step_idx);
      end
    end
    chk("loop_wraps", wraps, 3);
    chk("noloop_done", if0.done, 1);
    chk("noloop_sw", if0.Minisys_Switches, m_sw);
    pulse_abort();
    chk("abort_busy", if1.busy, 0);
    chk("abort_btn", if1.Minisys_Button, 0);
    chk("abort_done", if1.done, 0);
    chk("abort_idx", if1.step_idx, 0);
    chk("abort_sw_hold", if1.Minisys_Switches, m_sw);
    script_len = 0; start = 1;
    tick();
    start = 0;
    chk("len0_done", if0.done, 1);
    chk("len0_pass", if0.pass, 1);
    chk("len0_busy", if0.busy, 0);
    wr(0, 20, 24'h0f0000, 24'hff0000, 0, 1, 24'h123456);
    run_script(1, 24'h123456, 1);
    run_script(1, 24'h123456, 0);
    pulse_abort();
    wr(0, 1, 24'h0000ff, 24'h0000ff, 5'b10000, 0, 0);
    script_len = 1; start = 1;
    tick();
    start = 0;
    for (int c = 0; c < 20 && if0.Minisys_Button == 0; c++) tick();
    chk("pulse_seen", if0.Minisys_Button, 5'b10000);
    tick();
    tick();
    rst = 1;
    tick();
    chk("mid_rst_sw", if0.Minisys_Switches, 0);
    chk("mid_rst_btn", if0.Minisys_Button, 0);
    chk("mid_rst_busy", if0.busy, 0);
    chk("mid_rst_done", if0.done, 0);
    rst = 0;
    m_sw = '0;
    tick();
    run_script(1, 24'h0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
